bitfusion_pe: RTL and testbench

Parametrised, pipelined Bit-Fusion processing element that supersedes the fixed 8-bit fusion wrapper. It takes one packed input word and one packed weight word per beat, splits them into 1, 2 or 4 elements according to a per-beat precision mode, and forms the signed/unsigned dot product. It then adds either the systolic psum_in or an internal local accumulator and forwards the registered result. It sits in the systolic array column, with valid tagging and a global stall.

---
 rtl/bitfusion_pe_if.sv | 28 ++
 rtl/bitfusion_pe.sv | 122 ++++++++++++
 tb/tb_bitfusion_pe.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bitfusion_pe_if.sv
// Beat-level bus of the Bit-Fusion PE: controls and operands in, registered partial sum out.
interface bitfusion_pe_if #(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 19
) ();
    logic              en;
    logic              in_valid;
    logic [DATA_W-1:0] in;
    logic [DATA_W-1:0] weight;
    logic [PSUM_W-1:0] psum_in;
    logic [1:0]        mode;
    logic              s_in;
    logic              s_weight;
    logic              acc_local;
    logic              acc_clr;
    logic [PSUM_W-1:0] psum_fwd;
    logic              out_valid;

    modport master (
        output en, in_valid, in, weight, psum_in, mode, s_in, s_weight, acc_local, acc_clr,
        input  psum_fwd, out_valid
    );

    modport slave (
        input  en, in_valid, in, weight, psum_in, mode, s_in, s_weight, acc_local, acc_clr,
        output psum_fwd, out_valid
    );
endinterface

// File: rtl/bitfusion_pe.sv
// Three-stage Bit-Fusion PE: capture, fused dot product, accumulate into psum_in or a local acc.
module bitfusion_pe #(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    bitfusion_pe_if.slave bus
);
    localparam int H = DATA_W / 2;
    localparam int Q = DATA_W / 4;

    typedef enum logic [1:0] {
        MODE_X1  = 2'b00,
        MODE_X2  = 2'b01,
        MODE_X4  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    logic              s1_valid, s1_s_in, s1_s_weight, s1_acc_local, s1_acc_clr;
    logic [DATA_W-1:0] s1_in, s1_weight;
    logic [PSUM_W-1:0] s1_psum;
    logic [1:0]        s1_mode;

    logic              s2_valid, s2_acc_local, s2_acc_clr;
    logic [PSUM_W-1:0] s2_sum, s2_psum;

    logic [PSUM_W-1:0] acc, dot, ea, ew, base, result;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_in        <= '0;
            s1_weight    <= '0;
            s1_psum      <= '0;
            s1_mode      <= '0;
            s1_s_in      <= 1'b0;
            s1_s_weight  <= 1'b0;
            s1_acc_local <= 1'b0;
            s1_acc_clr   <= 1'b0;
        end else if (bus.en) begin
            s1_valid     <= bus.in_valid;
            s1_in        <= bus.in;
            s1_weight    <= bus.weight;
            s1_psum      <= bus.psum_in;
            s1_mode      <= bus.mode;
            s1_s_in      <= bus.s_in;
            s1_s_weight  <= bus.s_weight;
            s1_acc_local <= bus.acc_local;
            s1_acc_clr   <= bus.acc_clr;
        end
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        dot = '0;
        ea  = '0;
        ew  = '0;
        case (mode_e'(s1_mode))
            MODE_X2: begin
                for (int i = 0; i < 2; i++) begin
                    ea  = {{(PSUM_W-H){s1_s_in     & s1_in[i*H+H-1]}},     s1_in[i*H +: H]};
                    ew  = {{(PSUM_W-H){s1_s_weight & s1_weight[i*H+H-1]}}, s1_weight[i*H +: H]};
                    dot = dot + ea * ew;
                end
            end
            MODE_X4: begin
                for (int i = 0; i < 4; i++) begin
                    ea  = {{(PSUM_W-Q){s1_s_in     & s1_in[i*Q+Q-1]}},     s1_in[i*Q +: Q]};
                    ew  = {{(PSUM_W-Q){s1_s_weight & s1_weight[i*Q+Q-1]}}, s1_weight[i*Q +: Q]};
                    dot = dot + ea * ew;
                end
            end
            default: begin
                // The reserved encoding shares the single full-width element path.
                ea  = {{(PSUM_W-DATA_W){s1_s_in     & s1_in[DATA_W-1]}},     s1_in};
                ew  = {{(PSUM_W-DATA_W){s1_s_weight & s1_weight[DATA_W-1]}}, s1_weight};
                dot = ea * ew;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            s2_sum       <= '0;
            s2_psum      <= '0;
            s2_acc_local <= 1'b0;
            s2_acc_clr   <= 1'b0;
        end else if (bus.en) begin
            s2_valid     <= s1_valid;
            s2_sum       <= dot;
            s2_psum      <= s1_psum;
            s2_acc_local <= s1_acc_local;
            s2_acc_clr   <= s1_acc_clr;
        end
    end

    always_comb begin
        base = s2_psum;
        if (s2_acc_local) base = s2_acc_clr ? '0 : acc;
        result = base + s2_sum;
    end

    // NOTE: acc is architectural state read before any clear, so it is reset along with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            bus.psum_fwd  <= '0;
            bus.out_valid <= 1'b0;
        end else if (bus.en) begin
            if (s2_valid) begin
                bus.psum_fwd  <= result;
                bus.out_valid <= 1'b1;
                if (s2_acc_local) acc <= result;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bitfusion_pe.sv
// Randomised and directed bench for bitfusion_pe against an arithmetic reference model.
module tb_bitfusion_pe;
    localparam int DATA_W = 8;
    localparam int PSUM_W = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bitfusion_pe_if #(.DATA_W(DATA_W), .PSUM_W(PSUM_W)) bus ();

    bitfusion_pe #(.DATA_W(DATA_W), .PSUM_W(PSUM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: signed/unsigned element dot product in plain integer arithmetic.
    function automatic int dot_ref(input logic [7:0] a, input logic [7:0] w,
                                   input logic [1:0] m, input logic sa, input logic sw);
        int n, wd, ea, ew, s;
        n  = (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
        wd = DATA_W / n;
        s  = 0;
        for (int i = 0; i < n; i++) begin
            ea = (int'(a) >> (i * wd)) & ((1 << wd) - 1);
            ew = (int'(w) >> (i * wd)) & ((1 << wd) - 1);
            if (sa && ea >= (1 << (wd - 1))) ea -= (1 << wd);
            if (sw && ew >= (1 << (wd - 1))) ew -= (1 << wd);
            s += ea * ew;
        end
        return s;
    endfunction

    // Model state: results become visible two enabled edges after the sampling edge.
    logic              line_v [2];
    logic [PSUM_W-1:0] line_d [2];
    logic              exp_valid = 1'b0;
    logic [PSUM_W-1:0] exp_psum  = '0;
    logic [PSUM_W-1:0] m_acc     = '0;
    logic              last_en   = 1'b0;
    logic [PSUM_W-1:0] got_q [$];

    initial begin
        int base;
        logic [PSUM_W-1:0] r;
        line_v[0] = 1'b0; line_v[1] = 1'b0;
        line_d[0] = '0;   line_d[1] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                line_v[0] = 1'b0; line_v[1] = 1'b0;
                exp_valid = 1'b0; exp_psum = '0; m_acc = '0; last_en = 1'b0;
            end else begin
                last_en = bus.en;
                if (bus.en) begin
                    exp_valid = line_v[1];
                    if (line_v[1]) exp_psum = line_d[1];
                    line_v[1] = line_v[0];
                    line_d[1] = line_d[0];
                    line_v[0] = bus.in_valid;
                    if (bus.in_valid) begin
                        if (!bus.acc_local)   base = int'(bus.psum_in);
                        else if (bus.acc_clr) base = 0;
                        else                  base = int'(m_acc);
                        r = PSUM_W'(base + dot_ref(bus.in, bus.weight, bus.mode, bus.s_in, bus.s_weight));
                        if (bus.acc_local) m_acc = r;
                        line_d[0] = r;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("psum_fwd", 32'(bus.psum_fwd), 32'(exp_psum));
            if (bus.out_valid && last_en) got_q.push_back(bus.psum_fwd);
        end
    end

    task automatic beat(input logic [1:0] m, input logic si, input logic sw,
                        input logic [7:0] a, input logic [7:0] w,
                        input logic [PSUM_W-1:0] p, input logic al, input logic ac);
        bus.mode = m; bus.s_in = si; bus.s_weight = sw;
        bus.in = a; bus.weight = w; bus.psum_in = p;
        bus.acc_local = al; bus.acc_clr = ac; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en = 1'b1; bus.in_valid = 1'b0; bus.in = '0; bus.weight = '0; bus.psum_in = '0;
        bus.mode = '0; bus.s_in = 1'b0; bus.s_weight = 1'b0; bus.acc_local = 1'b0; bus.acc_clr = 1'b0;
        #12;
        check("rst_psum", 32'(bus.psum_fwd), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Signed single element: -1 * 2 + 10.
        got_q.delete();
        beat(2'b00, 1, 1, 8'hFF, 8'h02, 19'd10, 0, 0);
        idle(5);
        check("basic_count", got_q.size(), 1);
        if (got_q.size() > 0) check("basic_val", 32'(got_q[0]), 8);

        // Two lanes unsigned, then four lanes signed, back to back.
        got_q.delete();
        beat(2'b01, 0, 0, 8'h21, 8'h43, 19'd0, 0, 0);
        beat(2'b10, 1, 1, 8'hFF, 8'h55, 19'd0, 0, 0);
        idle(5);
        check("mix_count", got_q.size(), 2);
        if (got_q.size() > 1) begin
            check("mix_x2", 32'(got_q[0]), 11);
            check("mix_x4", 32'(got_q[1]), 32'h7FFFC);
        end

        // Local accumulation; idle beats carry acc controls and must not disturb acc.
        got_q.delete();
        beat(2'b00, 0, 0, 8'd3, 8'd4, 19'd100, 1, 1);
        bus.acc_local = 1'b1; bus.acc_clr = 1'b1; idle(1);
        beat(2'b00, 0, 0, 8'd1, 8'd5, 19'd100, 1, 0);
        bus.acc_local = 1'b1; bus.acc_clr = 1'b1; idle(1);
        beat(2'b00, 0, 0, 8'd1, 8'd5, 19'd100, 1, 0);
        idle(5);
        check("acc_count", got_q.size(), 3);
        if (got_q.size() > 2) begin
            check("acc_a", 32'(got_q[0]), 12);
            check("acc_b", 32'(got_q[1]), 17);
            check("acc_c", 32'(got_q[2]), 22);
        end

        // Stall mid-stream; a beat offered while stalled is not sampled.
        got_q.delete();
        beat(2'b01, 1, 0, 8'($urandom), 8'($urandom), 19'($urandom), 0, 0);
        beat(2'b10, 0, 1, 8'($urandom), 8'($urandom), 19'($urandom), 0, 0);
        bus.en = 1'b0; bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.en = 1'b1;
        beat(2'b00, 1, 1, 8'($urandom), 8'($urandom), 19'($urandom), 0, 0);
        beat(2'b11, 0, 0, 8'($urandom), 8'($urandom), 19'($urandom), 0, 0);
        idle(5);
        check("stall_count", got_q.size(), 4);

        // Wrap-around at PSUM_W bits.
        got_q.delete();
        beat(2'b00, 0, 0, 8'hFF, 8'hFF, 19'h7FFFF, 0, 0);
        idle(5);
        check("wrap_count", got_q.size(), 1);
        if (got_q.size() > 0) check("wrap_val", 32'(got_q[0]), 65024);

        // Random traffic including stalls, invalid beats and accumulator use.
        for (int c = 0; c < 400; c++) begin
            bus.en        = ($urandom_range(0, 7) != 0);
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.mode      = 2'($urandom);
            bus.s_in      = 1'($urandom);
            bus.s_weight  = 1'($urandom);
            bus.in        = 8'($urandom);
            bus.weight    = 8'($urandom);
            bus.psum_in   = 19'($urandom);
            bus.acc_local = 1'($urandom);
            bus.acc_clr   = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        bus.en = 1'b1;

        // Asynchronous reset with two accumulating beats in flight.
        beat(2'b00, 0, 0, 8'd9, 8'd9, 19'd0, 1, 0);
        beat(2'b00, 0, 0, 8'd7, 8'd7, 19'd0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_psum", 32'(bus.psum_fwd), 0);
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_acc", 32'(dut.acc), 0);
        got_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(6);
        check("arst_no_pulse", got_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
